// File: rtl/game_key_pkg.sv
// Shared key indices, PS/2 set-2 scan codes and decoder state type for the game keyboard path.
package game_key_pkg;

   localparam int NUM_KEYS  = 7;
   localparam int KEY_IDX_W = 3;

   localparam logic [KEY_IDX_W-1:0] KEY_LEFT  = 3'd0;
   localparam logic [KEY_IDX_W-1:0] KEY_RIGHT = 3'd1;
   localparam logic [KEY_IDX_W-1:0] KEY_UP    = 3'd2;
   localparam logic [KEY_IDX_W-1:0] KEY_DOWN  = 3'd3;
   localparam logic [KEY_IDX_W-1:0] KEY_SPACE = 3'd4;
   localparam logic [KEY_IDX_W-1:0] KEY_ENTER = 3'd5;
   localparam logic [KEY_IDX_W-1:0] KEY_ESC   = 3'd6;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_ESC   = 8'h76;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } key_state_t;

endpackage

// File: rtl/ps2_key_lookup.sv
// Combinational map from {extended, scan code} to a game key index; o_hit is 0 for unmapped codes.
module ps2_key_lookup
   import game_key_pkg::*;
(
   input  logic                 i_ext,
   input  logic [7:0]           i_code,
   output logic                 o_hit,
   output logic [KEY_IDX_W-1:0] o_idx
);

   always_comb begin
      o_hit = 1'b1;
      o_idx = KEY_LEFT;
      case ({i_ext, i_code})
         {1'b1, SC_LEFT}:  o_idx = KEY_LEFT;
         {1'b1, SC_RIGHT}: o_idx = KEY_RIGHT;
         {1'b1, SC_UP}:    o_idx = KEY_UP;
         {1'b1, SC_DOWN}:  o_idx = KEY_DOWN;
         {1'b0, SC_SPACE}: o_idx = KEY_SPACE;
         {1'b0, SC_ENTER}: o_idx = KEY_ENTER;
         {1'b0, SC_ESC}:   o_idx = KEY_ESC;
         default:          o_hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder: E0/F0 prefix FSM with stall timeout, per-key held state and make/break pulses.
// Optional macro KEY_TYPEMATIC_FILTER_EN suppresses key_press for typematic repeats of a held key.
module ps2_key_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
   parameter int unsigned NUM_KEYS       = 7
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [7:0]          dat_out,
   input  logic                dat_ready,
   input  logic                dat_busy,
   output logic [NUM_KEYS-1:0] key_down,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                code_valid,
   output logic [8:0]          last_code
);
   import game_key_pkg::*;

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   key_state_t           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_ready_d;
   logic                 r_code_valid;
   logic [8:0]           r_last_code;

   key_state_t           w_next_state;
   logic                 w_accept;
   logic                 w_make;
   logic                 w_break;
   logic                 w_ext;
   logic                 w_done;
   logic                 w_hit;
   logic [KEY_IDX_W-1:0] w_idx;

   assign w_accept = dat_ready & ~r_ready_d & ~dat_busy;

   always_comb begin
      w_next_state = r_state;
      w_make       = 1'b0;
      w_break      = 1'b0;
      w_ext        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (dat_out == SC_EXT)      w_next_state = ST_EXT;
            else if (dat_out == SC_BRK) w_next_state = ST_BRK;
            else                        w_make = 1'b1;
         end
         ST_EXT: begin
            if (dat_out == SC_EXT) begin
               w_next_state = ST_EXT;
            end else if (dat_out == SC_BRK) begin
               w_next_state = ST_EXT_BRK;
            end else begin
               w_make       = 1'b1;
               w_ext        = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         ST_BRK: begin
            w_break      = 1'b1;
            w_next_state = ST_IDLE;
         end
         ST_EXT_BRK: begin
            w_break      = 1'b1;
            w_ext        = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_done = w_accept & (w_make | w_break);

   ps2_key_lookup u_lookup (
      .i_ext  (w_ext),
      .i_code (dat_out),
      .o_hit  (w_hit),
      .o_idx  (w_idx)
   );

   // An accept always wins over the timeout, so it is tested first.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_ready_d    <= 1'b0;
         r_code_valid <= 1'b0;
         r_last_code  <= '0;
      end else begin
         r_ready_d    <= dat_ready;
         r_code_valid <= w_done;
         if (w_done)
            r_last_code <= {w_ext, dat_out};
         if (w_accept) begin
            r_state <= w_next_state;
            r_cnt   <= '0;
         end else if (r_state != ST_IDLE) begin
            if (r_cnt == CNT_LAST) begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign code_valid = r_code_valid;
   assign last_code  = r_last_code;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         logic r_down;
         logic r_press;
         logic r_rel;
         logic w_sel;

         assign w_sel = w_done & w_hit & (w_idx == KEY_IDX_W'(gi));

         always_ff @(posedge clock) begin
            if (!resetn) begin
               r_down  <= 1'b0;
               r_press <= 1'b0;
               r_rel   <= 1'b0;
            end else begin
               r_press <= 1'b0;
               r_rel   <= 1'b0;
               if (w_sel && w_make) begin
                  r_down  <= 1'b1;
`ifdef KEY_TYPEMATIC_FILTER_EN
                  r_press <= ~r_down;
`else
                  r_press <= 1'b1;
`endif
               end else if (w_sel && w_break) begin
                  r_down <= 1'b0;
                  r_rel  <= 1'b1;
               end
            end
         end

         assign key_down[gi]    = r_down;
         assign key_press[gi]   = r_press;
         assign key_release[gi] = r_rel;
      end
   endgenerate

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: a reference decoder pushes expected events as bytes are sent; a monitor pops and compares.
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] dat_out = 8'h00;
   logic       dat_ready = 1'b0;
   logic       dat_busy = 1'b0;
   logic [6:0] key_down, key_press, key_release;
   logic       code_valid;
   logic [8:0] last_code;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ps2_key_decoder #(.TIMEOUT_CYCLES(16), .NUM_KEYS(7)) dut (
      .clock       (clk),
      .resetn      (resetn),
      .dat_out     (dat_out),
      .dat_ready   (dat_ready),
      .dat_busy    (dat_busy),
      .key_down    (key_down),
      .key_press   (key_press),
      .key_release (key_release),
      .code_valid  (code_valid),
      .last_code   (last_code)
   );

   typedef struct packed {
      logic [8:0] code;
      logic [6:0] press;
      logic [6:0] rel;
      logic [6:0] down;
   } exp_t;

   exp_t q[$];

   // Reference model state: 0 idle, 1 ext, 2 brk, 3 ext+brk
   int         m_st = 0;
   logic [6:0] m_down = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int key_of(input bit ext, input logic [7:0] c);
      if (ext) begin
         if (c == 8'h6B) return 0;
         if (c == 8'h74) return 1;
         if (c == 8'h75) return 2;
         if (c == 8'h72) return 3;
      end else begin
         if (c == 8'h29) return 4;
         if (c == 8'h5A) return 5;
         if (c == 8'h76) return 6;
      end
      return -1;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      bit   done = 0;
      bit   brk = 0;
      bit   ext = 0;
      int   k;
      exp_t e;
      case (m_st)
         0: if (b == 8'hE0) m_st = 1; else if (b == 8'hF0) m_st = 2; else done = 1;
         1: if (b == 8'hE0) m_st = 1; else if (b == 8'hF0) m_st = 3;
            else begin done = 1; ext = 1; m_st = 0; end
         2: begin done = 1; brk = 1; m_st = 0; end
         default: begin done = 1; brk = 1; ext = 1; m_st = 0; end
      endcase
      if (done) begin
         e.code  = {ext, b};
         e.press = '0;
         e.rel   = '0;
         k = key_of(ext, b);
         if (k >= 0) begin
            if (brk) begin
               e.rel[k]  = 1'b1;
               m_down[k] = 1'b0;
            end else begin
`ifdef KEY_TYPEMATIC_FILTER_EN
               e.press[k] = ~m_down[k];
`else
               e.press[k] = 1'b1;
`endif
               m_down[k] = 1'b1;
            end
         end
         e.down = m_down;
         q.push_back(e);
      end
   endtask

   task automatic send(input logic [7:0] b, input int hold = 1, input bit busy = 0);
      @(negedge clk);
      if (!busy) model_byte(b);
      $display("send byte %02h hold=%0d busy=%0d", b, hold, busy);
      dat_out   = b;
      dat_busy  = busy;
      dat_ready = 1'b1;
      repeat (hold) @(negedge clk);
      dat_ready = 1'b0;
      dat_busy  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_down"}, 32'(key_down), 32'h0);
      chk({tag, "_press"}, 32'(key_press), 32'h0);
      chk({tag, "_release"}, 32'(key_release), 32'h0);
      chk({tag, "_valid"}, 32'(code_valid), 32'h0);
      chk({tag, "_last"}, 32'(last_code), 32'h0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      check_cleared("mid_reset");
      resetn = 1'b1;
      m_st   = 0;
      m_down = '0;
   endtask

   logic prev_evt = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      logic evt;
      evt = code_valid | (|key_press) | (|key_release);
      if (resetn) begin
         if (prev_evt)
            chk("pulse_clear", 32'({code_valid, key_press, key_release}), 32'h0);
         if (evt) begin
            if (q.size() == 0) begin
               chk("unexpected_evt", 32'({code_valid, key_press, key_release}), 32'h0);
            end else begin
               e = q.pop_front();
               $display("event last_code=%03h press=%02h release=%02h down=%02h", last_code, key_press, key_release, key_down);
               chk("code_valid", 32'(code_valid), 32'h1);
               chk("last_code", 32'(last_code), 32'(e.code));
               chk("key_press", 32'(key_press), 32'(e.press));
               chk("key_release", 32'(key_release), 32'(e.rel));
               chk("key_down", 32'(key_down), 32'(e.down));
            end
         end
      end
      prev_evt = evt & resetn;
   end

   initial begin
      repeat (3) @(negedge clk);
      check_cleared("reset");
      resetn = 1'b1;

      // SPACE make then break
      send(8'h29); send(8'hF0); send(8'h29);
      // LEFT extended make then extended break
      send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
      // 75 without E0 is unmapped
      send(8'h75);
      // Stalled E0 times out; following 6B is a normal (unmapped) code
      send(8'hE0);
      repeat (20) @(negedge clk);
      m_st = 0;
      send(8'h6B);
      // ENTER typematic repeat then release
      send(8'h5A); send(8'h5A); send(8'h5A); send(8'hF0); send(8'h5A);
      // Byte with busy set is dropped
      send(8'h29, 2, 1'b1);
      // Back-to-back prefixes
      send(8'hE0); send(8'hE0); send(8'h75);
      send(8'hF0); send(8'hF0);
      send(8'hE0); send(8'hF0); send(8'h75);
      // Break of a key not held
      send(8'hF0); send(8'h76);
      // Reset mid-sequence with SPACE held
      send(8'h29); send(8'hE0); send(8'hF0);
      pulse_reset();
      send(8'h6B);
      send(8'hE0); send(8'h6B);
      // dat_ready held high for 5 cycles gives one accept
      send(8'h76, 5);

      repeat (10) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
